// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer scanout.
//   - Buffer geometry (320x240 RGB332 by default) and address width.
//   - RGB332 field positions inside a stored pixel.
//   - State encodings for the swap and clear FSMs.
//   - fb_addr(): y*w + x built from shifted copies of y (constant shift-add).
package fb_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;

    // RGB332 field positions
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef enum logic {SWAP_IDLE = 1'b0, SWAP_PEND = 1'b1} swap_state_e;
    typedef enum logic {CLR_IDLE  = 1'b0, CLR_RUN   = 1'b1} clr_state_e;

    // Linear address y*w + x. w is an elaboration-time constant, so the loop
    // collapses to a fixed set of shifted adds (320 = 256 + 64).
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] y,
                                                  input logic [ADDR_W-1:0] x,
                                                  input int                w);
        logic [ADDR_W-1:0] acc;
        acc = x;
        for (int i = 0; i < ADDR_W; i++) begin
            if (w[i]) acc = acc + (y << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_dual_ram.sv
// Simple dual-port RAM used as one framebuffer bank.
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port (written on the clock edge)
//   re_i/raddr_i     read enable and address
//   rdata_o          registered read data, one cycle after re_i
module fb_dual_ram #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// Double-buffered framebuffer between draw logic and the VGA timing generator.
//   real100clock, reset_n            clock, async active-low reset
//   pix_en, x_pixel, y_pixel, active_in, vsync_n   timing-generator inputs
//   wr_req/wr_x/wr_y/wr_color, wr_ready, wr_oob     back-buffer write port
//   clr_req/clr_color                hardware clear of the back buffer
//   swap_req, swap_done, front_sel   front/back swap, taken at vsync fall
//   vga_r/g/b, active_out            RGB888 out, 3 pix_en ticks after input
module fb_scanout
    import fb_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int PIX_W       = 8
) (
    input  logic             real100clock,
    input  logic             reset_n,
    input  logic             pix_en,
    input  logic [9:0]       x_pixel,
    input  logic [8:0]       y_pixel,
    input  logic             active_in,
    input  logic             vsync_n,
    input  logic             wr_req,
    input  logic [8:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic [PIX_W-1:0] wr_color,
    output logic             wr_ready,
    output logic             wr_oob,
    input  logic             clr_req,
    input  logic [PIX_W-1:0] clr_color,
    input  logic             swap_req,
    output logic             swap_done,
    output logic             front_sel,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             active_out
);

    localparam int W     = H_RES >> SCALE_SHIFT;
    localparam int H     = V_RES >> SCALE_SHIFT;
    localparam int DEPTH = W * H;

    swap_state_e       swap_q, swap_d;
    clr_state_e        clr_q, clr_d;
    logic              front_q, front_d;
    logic              done_q, done_d;
    logic              oob_q, oob_d;
    logic              vs_q, vs_fall;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0]  clr_col_q, clr_col_d;

    logic              wr_out_of_range, we_any, we0, we1;
    logic [ADDR_W-1:0] waddr;
    logic [PIX_W-1:0]  wdata;

    logic [ADDR_W-1:0] addr_p1_q;
    logic              vld_p1_q, vld_p2_q, vld_p3_q, sel_p2_q;
    logic [PIX_W-1:0]  rd0, rd1, pix_p2;
    logic [23:0]       rgb_p3_q;

    // RGB332 to RGB888 by bit replication of each field.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[R_MSB:R_LSB];
        g = c[G_MSB:G_LSB];
        b = c[B_MSB:B_LSB];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    assign wr_ready        = (clr_q == CLR_IDLE);
    assign wr_out_of_range = (int'(wr_x) >= W) || (int'(wr_y) >= H);
    assign vs_fall         = vs_q & ~vsync_n;

    // Both FSMs: clear sweep of the back bank and vsync-aligned swap.
    always_comb begin
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        clr_col_d = clr_col_q;
        swap_d    = swap_q;
        front_d   = front_q;
        done_d    = 1'b0;
        oob_d     = wr_req & wr_ready & wr_out_of_range;

        case (clr_q)
            CLR_IDLE: if (clr_req) begin
                clr_d     = CLR_RUN;
                cnt_d     = '0;
                clr_col_d = clr_color;
            end
            CLR_RUN: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) clr_d = CLR_IDLE;
                else                             cnt_d = cnt_q + ADDR_W'(1);
            end
            default: clr_d = CLR_IDLE;
        endcase

        case (swap_q)
            SWAP_IDLE: if (swap_req) swap_d = SWAP_PEND;
            // A swap while clearing would expose a half-cleared frame; wait
            // for the next vsync fall instead.
            SWAP_PEND: if (vs_fall && clr_q == CLR_IDLE) begin
                front_d = ~front_q;
                done_d  = 1'b1;
                swap_d  = SWAP_IDLE;
            end
            default: swap_d = SWAP_IDLE;
        endcase
    end

    // Clear sweep owns the write port while running; otherwise draw writes.
    always_comb begin
        we_any = 1'b0;
        waddr  = fb_addr(ADDR_W'(wr_y), ADDR_W'(wr_x), W);
        wdata  = wr_color;
        if (clr_q == CLR_RUN) begin
            we_any = 1'b1;
            waddr  = cnt_q;
            wdata  = clr_col_q;
        end else if (wr_req && !wr_out_of_range) begin
            we_any = 1'b1;
        end
    end

    // Back bank is the one not displayed.
    assign we0 = we_any &  front_q;
    assign we1 = we_any & ~front_q;

    always_ff @(posedge real100clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_q    <= CLR_IDLE;
            cnt_q    <= '0;
            swap_q   <= SWAP_IDLE;
            front_q  <= 1'b0;
            done_q   <= 1'b0;
            oob_q    <= 1'b0;
            vs_q     <= 1'b1;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            rgb_p3_q <= '0;
        end else begin
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            swap_q  <= swap_d;
            front_q <= front_d;
            done_q  <= done_d;
            oob_q   <= oob_d;
            vs_q    <= vsync_n;
            if (pix_en) begin
                vld_p1_q <= active_in;
                vld_p2_q <= vld_p1_q;
                vld_p3_q <= vld_p2_q;
                rgb_p3_q <= vld_p2_q ? rgb332_expand(pix_p2) : 24'd0;
            end
        end
    end

    always_ff @(posedge real100clock) begin
        clr_col_q <= clr_col_d;
        // Stage 1: screen coordinate to buffer address
        if (pix_en) begin
            addr_p1_q <= fb_addr(ADDR_W'(y_pixel >> SCALE_SHIFT),
                                 ADDR_W'(x_pixel >> SCALE_SHIFT), W);
            sel_p2_q  <= front_q;
        end
    end

    // Stage 2: bank read; the select is captured with the read so a swap
    // never redirects a pixel already in flight.
    fb_dual_ram #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(PIX_W)) u_bank0 (
        .clk_i   (real100clock),
        .we_i    (we0),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (pix_en),
        .raddr_i (addr_p1_q),
        .rdata_o (rd0)
    );

    fb_dual_ram #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(PIX_W)) u_bank1 (
        .clk_i   (real100clock),
        .we_i    (we1),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (pix_en),
        .raddr_i (addr_p1_q),
        .rdata_o (rd1)
    );

    assign pix_p2 = sel_p2_q ? rd1 : rd0;

    // Stage 3: expanded colour, blanked outside the visible area
    assign vga_r      = rgb_p3_q[23:16];
    assign vga_g      = rgb_p3_q[15:8];
    assign vga_b      = rgb_p3_q[7:0];
    assign active_out = vld_p3_q;
    assign wr_oob     = oob_q;
    assign swap_done  = done_q;
    assign front_sel  = front_q;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;
    import fb_pkg::*;

    logic       real100clock = 1'b0;
    logic       reset_n;
    logic       pix_en;
    logic [9:0] x_pixel;
    logic [8:0] y_pixel;
    logic       active_in;
    logic       vsync_n;
    logic       wr_req;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_color;
    logic       wr_ready;
    logic       wr_oob;
    logic       clr_req;
    logic [7:0] clr_color;
    logic       swap_req;
    logic       swap_done;
    logic       front_sel;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       active_out;

    fb_scanout dut (
        .real100clock (real100clock),
        .reset_n      (reset_n),
        .pix_en       (pix_en),
        .x_pixel      (x_pixel),
        .y_pixel      (y_pixel),
        .active_in    (active_in),
        .vsync_n      (vsync_n),
        .wr_req       (wr_req),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_color     (wr_color),
        .wr_ready     (wr_ready),
        .wr_oob       (wr_oob),
        .clr_req      (clr_req),
        .clr_color    (clr_color),
        .swap_req     (swap_req),
        .swap_done    (swap_done),
        .front_sel    (front_sel),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .active_out   (active_out)
    );

    always #5 real100clock = ~real100clock;

    int comps = 0;
    int fails = 0;

    // Reference model: two banks as plain arrays, a known-map for cells the
    // bench has defined, and a list of pixels in flight.
    logic [7:0] m_mem   [2][FB_DEPTH];
    bit         m_known [2][FB_DEPTH];
    int         m_front, m_clr_left, m_clr_addr;
    bit         m_pend, m_vs_prev;
    logic [7:0] m_clr_col;

    typedef struct {
        bit         act;
        int         addr;
        logic [7:0] col;
        bit         known;
    } samp_t;
    samp_t pipe[$];

    bit          e_act, e_rchk, e_oob, e_done, e_ready;
    logic [23:0] e_rgb;

    int done_cnt, oob_cnt, low_cnt, red_cnt;
    int xmax, ymax;
    bit quiet;
    int dq_x[$], dq_y[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        comps++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp332(input logic [7:0] c);
        logic [2:0] r3, g3;
        logic [1:0] b2;
        r3 = c[7:5];
        g3 = c[4:2];
        b2 = c[1:0];
        return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
    endfunction

    task automatic model_reset(input bit forget);
        m_front = 0; m_pend = 0; m_clr_left = 0; m_clr_addr = 0; m_vs_prev = 1;
        pipe.delete();
        e_act = 0; e_rgb = '0; e_rchk = 1; e_oob = 0; e_done = 0; e_ready = 1;
        if (forget)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < FB_DEPTH; a++) m_known[b][a] = 0;
    endtask

    // Effect of one clock edge given the inputs currently applied.
    task automatic model_step();
        bit    clearing, fall;
        int    back;
        samp_t s;
        clearing = (m_clr_left > 0);
        back     = 1 - m_front;
        fall     = m_vs_prev && !vsync_n;
        e_oob    = 0;
        e_done   = 0;
        if (pix_en) begin
            if (pipe.size() > 0) begin
                s = pipe.pop_back();
                s.col   = m_mem[m_front][s.addr];
                s.known = m_known[m_front][s.addr];
                pipe.push_back(s);
            end
            s.act   = active_in;
            s.addr  = int'(y_pixel >> 1) * FB_W + int'(x_pixel >> 1);
            s.col   = '0;
            s.known = 0;
            pipe.push_back(s);
            if (pipe.size() > 3) void'(pipe.pop_front());
            e_act = 0; e_rgb = '0; e_rchk = 1;
            if (pipe.size() == 3 && pipe[0].act) begin
                e_act  = 1;
                e_rgb  = exp332(pipe[0].col);
                e_rchk = pipe[0].known;
            end
        end
        if (wr_req && !clearing) begin
            if (int'(wr_x) >= FB_W || int'(wr_y) >= FB_H) e_oob = 1;
            else begin
                m_mem[back][int'(wr_y) * FB_W + int'(wr_x)]   = wr_color;
                m_known[back][int'(wr_y) * FB_W + int'(wr_x)] = 1;
            end
        end
        if (clearing) begin
            m_mem[back][m_clr_addr]   = m_clr_col;
            m_known[back][m_clr_addr] = 1;
            m_clr_addr++;
            m_clr_left--;
        end else if (clr_req) begin
            m_clr_left = FB_DEPTH;
            m_clr_addr = 0;
            m_clr_col  = clr_color;
        end
        if (m_pend && fall && !clearing) begin
            m_front = 1 - m_front;
            e_done  = 1;
            m_pend  = 0;
        end else if (!m_pend && swap_req) begin
            m_pend = 1;
        end
        m_vs_prev = vsync_n;
        e_ready   = (m_clr_left == 0);
    endtask

    task automatic cycle();
        pix_en = ~pix_en;
        if (pix_en) begin
            if (dq_x.size() > 0) begin
                x_pixel   = 10'(dq_x.pop_front());
                y_pixel   = 9'(dq_y.pop_front());
                active_in = 1'b1;
            end else begin
                x_pixel   = 10'($urandom_range(0, xmax));
                y_pixel   = 9'($urandom_range(0, ymax));
                active_in = quiet ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
        model_step();
        @(posedge real100clock);
        #1;
        check_eq("wr_ready", 32'(wr_ready), 32'(e_ready));
        check_eq("wr_oob", 32'(wr_oob), 32'(e_oob));
        check_eq("swap_done", 32'(swap_done), 32'(e_done));
        check_eq("front_sel", 32'(front_sel), 32'(m_front));
        if (swap_done) done_cnt++;
        if (wr_oob) oob_cnt++;
        if (!wr_ready) low_cnt++;
        if (pix_en) begin
            check_eq("active_out", 32'(active_out), 32'(e_act));
            if (e_rchk) check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
            if (active_out && vga_r == 8'hFF && vga_g == 8'h00 && vga_b == 8'h00) red_cnt++;
        end
        wr_req = 0; clr_req = 0; swap_req = 0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_write(input int x, input int y, input int c);
        wr_req = 1; wr_x = 9'(x); wr_y = 8'(y); wr_color = 8'(c);
        cycle();
    endtask

    task automatic vsync_pulse();
        vsync_n = 0; run(4);
        vsync_n = 1; run(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_front_sel"}, 32'(front_sel), 32'd0);
        check_eq({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq({tag, "_active_out"}, 32'(active_out), 32'd0);
        check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check_eq({tag, "_wr_oob"}, 32'(wr_oob), 32'd0);
        check_eq({tag, "_swap_done"}, 32'(swap_done), 32'd0);
    endtask

    task automatic release_reset();
        wr_req = 0; clr_req = 0; swap_req = 0; pix_en = 0; active_in = 0; vsync_n = 1;
        repeat (2) @(posedge real100clock);
        #1;
        reset_n = 1;
        model_reset(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset_n = 0; pix_en = 0; x_pixel = 0; y_pixel = 0; active_in = 0; vsync_n = 1;
        wr_req = 0; wr_x = 0; wr_y = 0; wr_color = 0; clr_req = 0; clr_color = 0; swap_req = 0;
        xmax = 639; ymax = 479; quiet = 0;
        done_cnt = 0; oob_cnt = 0; low_cnt = 0; red_cnt = 0;
        model_reset(1);
        repeat (3) @(posedge real100clock);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Unknown front bank: only timing of active_out and blanking checked.
        run(200);

        // Fill a 16x16 corner of the back bank, (5,7) red, then off-range writes.
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                c = $urandom_range(0, 255);
                if (c == 8'hE0) c = 8'h1F;
                if (x == 5 && y == 7) c = 8'hE0;
                do_write(x, y, c);
            end
        do_write(320, 0, 8'h55);
        do_write(0, 240, 8'h55);
        do_write(511, 255, 8'h55);
        run(4);
        check_eq("oob_pulses", 32'(oob_cnt), 32'd3);
        for (int i = 0; i < 60; i++)
            do_write($urandom_range(0, 319), $urandom_range(16, 239), $urandom_range(0, 255));

        // Request on the same cycle as a vsync fall: swap waits for the next fall.
        swap_req = 1; vsync_n = 0; run(4);
        vsync_n = 1; run(4);
        check_eq("no_swap_same_edge", 32'(done_cnt), 32'd0);
        vsync_pulse();
        check_eq("swap1_done", 32'(done_cnt), 32'd1);
        check_eq("swap1_front", 32'(front_sel), 32'd1);

        // Display the written corner, then the four screen pixels of (5,7).
        xmax = 31; ymax = 31;
        run(400);
        quiet = 1;
        run(8);
        red_cnt = 0;
        dq_x = '{10, 11, 10, 11};
        dq_y = '{14, 14, 15, 15};
        run(16);
        check_eq("red_pixels", 32'(red_cnt), 32'd4);
        quiet = 0;

        // Clear of the back bank; requests during the clear.
        xmax = 639; ymax = 479;
        low_cnt = 0;
        clr_color = 8'h1C; clr_req = 1; cycle();
        run(1000);
        clr_color = 8'h03; clr_req = 1; cycle();
        do_write(3, 3, 8'h55);
        swap_req = 1; cycle();
        vsync_pulse();
        check_eq("no_swap_while_clear", 32'(done_cnt), 32'd1);
        run(75500);
        for (int i = 0; i < 2000 && !wr_ready; i++) cycle();
        run(10);
        check_eq("clear_low_cycles", 32'(low_cnt), 32'd76800);
        check_eq("front_after_clear", 32'(front_sel), 32'd1);
        vsync_pulse();
        check_eq("swap2_done", 32'(done_cnt), 32'd2);
        check_eq("swap2_front", 32'(front_sel), 32'd0);
        run(600);

        // Swap back, then reset in the middle of a clear with a swap pending.
        swap_req = 1; cycle();
        vsync_pulse();
        check_eq("swap3_front", 32'(front_sel), 32'd1);
        clr_color = 8'h4A; clr_req = 1; cycle();
        run(300);
        swap_req = 1; cycle();
        vsync_pulse();
        check_eq("pending_held", 32'(done_cnt), 32'd3);
        #2;
        reset_n = 0;
        #1;
        check_reset_outputs("midreset");
        release_reset();
        run(20);
        vsync_pulse();
        run(20);
        check_eq("no_swap_after_reset", 32'(done_cnt), 32'd3);
        check_eq("front_after_reset", 32'(front_sel), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
